// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with registered one-hot grant and index.
// Optional hold timeout compiled in with ARB_RR4_TIMEOUT_EN (uses MAX_HOLD).
module arb_rr4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] gidx,
  output logic       busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb_rr4: MAX_HOLD must be within 1..255");
  end

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gidx_d;
  logic [3:0] grant_d;
  logic       busy_d;
  logic [1:0] winner;
  logic       any_req;
  logic       force_release;

`ifdef ARB_RR4_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;

  assign force_release = (cnt_q == HOLD_LAST);
`else
  assign force_release = 1'b0;
`endif

  assign any_req = |req;

  // Search starts at ptr and walks upward mod 4; first requester seen wins.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    logic [1:0] idx;
    logic       found;
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx;
    grant_d = grant;
    busy_d  = busy;
`ifdef ARB_RR4_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_GRANT;
          gidx_d  = winner;
          grant_d = 4'b0001 << winner;
          busy_d  = 1'b1;
`ifdef ARB_RR4_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_GRANT: begin
        // Only the winner's own request matters while a tenure is open.
        if (!req[gidx] || force_release) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = gidx + 2'd1;
        end else begin
`ifdef ARB_RR4_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers only these few flops; there is no storage array to clear.
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gidx    <= 2'd0;
      grant   <= 4'b0000;
      busy    <= 1'b0;
`ifdef ARB_RR4_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx    <= gidx_d;
      grant   <= grant_d;
      busy    <= busy_d;
`ifdef ARB_RR4_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_arb_rr4.sv
// Self-checking bench for arb_rr4: directed scenarios plus randomized requests
// compared every cycle against a behavioural round-robin model.
module tb_arb_rr4;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds the resource, who was last granted, where the search starts.
  bit m_busy = 1'b0;
  int m_gidx = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  arb_rr4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant),
    .gidx  (gidx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] r);
    bit found;
    bit rel;
    if (rst) begin
      m_busy = 1'b0;
      m_gidx = 0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (r != 4'b0000) begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!found && r[(m_ptr + i) % 4]) begin
            m_gidx = (m_ptr + i) % 4;
            found  = 1'b1;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      rel = !r[m_gidx];
`ifdef ARB_RR4_TIMEOUT_EN
      if (m_cnt == MAX_HOLD - 1) rel = 1'b1;
`endif
      if (rel) begin
        m_busy = 1'b0;
        m_ptr  = (m_gidx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
  task automatic cycle(input logic rst, input logic [3:0] r);
    logic [7:0] exp_grant;
    @(negedge clk);
    reset = rst;
    req   = r;
    @(posedge clk);
    model_edge(rst, r);
    #1;
    exp_grant = m_busy ? (8'd1 << m_gidx) : 8'd0;
    check("grant", {4'b0, grant}, exp_grant);
    check("gidx", {6'b0, gidx}, 8'(m_gidx));
    check("busy", {7'b0, busy}, {7'b0, m_busy});
  endtask

  initial begin
    int         ten;
    int         winners[$];
    bit         prev_busy;
    logic [3:0] r;
    logic [3:0] prev_r;

    // Reset in the middle of a tenure, then regrant one cycle after reset drops.
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);
    check("reset_idle_grant", {4'b0, grant}, 8'h00);
    repeat (3) cycle(1'b0, 4'b0100);
    cycle(1'b1, 4'b0100);
    check("midtenure_reset_grant", {4'b0, grant}, 8'h00);
    check("midtenure_reset_gidx", {6'b0, gidx}, 8'h00);
    cycle(1'b0, 4'b0100);
    check("regrant_after_reset", {4'b0, grant}, 8'h04);

    // Rotation with all requesters: each winner drops for one cycle after three grant cycles.
    cycle(1'b1, 4'b0000);
    ten = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 21; c++) begin
      r = (m_busy && ten == 3) ? (4'hF & ~(4'b0001 << m_gidx)) : 4'hF;
      cycle(1'b0, r);
      ten = m_busy ? ten + 1 : 0;
      if (busy && !prev_busy) winners.push_back(int'(gidx));
      prev_busy = busy;
    end
    check("rotation_count", 8'(winners.size() >= 5), 8'd1);
    for (int i = 0; i < 5 && i < winners.size(); i++)
      check("rotation_order", 8'(winners[i]), 8'(i % 4));

    // Pointer wraps after requester 3 and skips an idle requester 0.
    cycle(1'b1, 4'b0000);
    repeat (2) cycle(1'b0, 4'b1000);
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b0110);
    check("wrap_skip_grant", {4'b0, grant}, 8'h02);

    // Non-winner noise never disturbs an open tenure.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0001);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, {3'($urandom), 1'b1});
      check("noise_grant_held", {4'b0, grant}, 8'h01);
    end

    // Winner 1 releases on the same edge requester 0 asserts.
    cycle(1'b1, 4'b0000);
    repeat (2) cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b0001);
    check("simul_idle", {4'b0, grant}, 8'h00);
    cycle(1'b0, 4'b0001);
    check("simul_then_grant0", {4'b0, grant}, 8'h01);

    // Two requesters held constant: behaviour follows the compiled-in timeout setting.
    cycle(1'b1, 4'b0000);
    repeat (20) cycle(1'b0, 4'b0011);

    // Randomized traffic with sticky requests and occasional resets.
    prev_r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 3) != 0) ? prev_r : 4'($urandom);
      prev_r = r;
      cycle(($urandom_range(0, 63) == 0), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
